// File: rtl/timer_pkg.sv
// Shared types and default widths for the timer counting stage.
package timer_pkg;

  // Default width of the main counter and compare value.
  localparam int CNT_WIDTH_DEF   = 32;
  // Default width of the prescaler value and prescaler counter.
  localparam int PRESC_WIDTH_DEF = 8;

  // Control states of the tick counter.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Event prescaler: emits one increment request every (cfg_presc_i+1) events.
// The >= comparison keeps the period bounded when the divider is lowered
// below the current prescaler count while running.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_WIDTH = PRESC_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   evt_i,
  input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
  input  logic                   clr_i,
  output logic                   inc_o
);

  logic [PRESC_WIDTH-1:0] r_presc;
  logic                   w_wrap;

  assign w_wrap = (r_presc >= cfg_presc_i);
  assign inc_o  = evt_i & w_wrap;

  // Prescaler counter: cleared on clr, wraps on terminal count, else counts events.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc <= {PRESC_WIDTH{1'b0}};
    end else if (clr_i) begin
      r_presc <= {PRESC_WIDTH{1'b0}};
    end else if (evt_i) begin
      if (w_wrap) begin
        r_presc <= {PRESC_WIDTH{1'b0}};
      end else begin
        r_presc <= r_presc + {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      r_presc <= r_presc;
    end
  end

endmodule : timer_prescaler

// File: rtl/timer_tick_counter.sv
// Timer counting stage: selects the count event source, divides it through the
// prescaler, advances the compare counter and pulses irq_o on a compare match.
// Supports continuous (auto-reload) and one-shot operation.
module timer_tick_counter
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int PRESC_WIDTH = PRESC_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   tick_i,
  input  logic                   cfg_en_i,
  input  logic                   cfg_ref_sel_i,
  input  logic                   cfg_oneshot_i,
  input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
  input  logic [CNT_WIDTH-1:0]   cmp_i,
  input  logic                   clr_i,
  input  logic                   cnt_wr_i,
  input  logic [CNT_WIDTH-1:0]   cnt_wdata_i,
  output logic [CNT_WIDTH-1:0]   cnt_o,
  output logic                   irq_o,
  output logic                   busy_o
);

  timer_state_e         r_state;
  timer_state_e         w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_irq;
  logic                 r_busy;

  logic w_evt;
  logic w_presc_clr;
  logic w_inc;
  logic w_inc_eff;
  logic w_match;
  logic w_all_ones;
  logic w_fire;

  // Events only exist while running; the external pulse or every clock cycle.
  assign w_evt       = (r_state == RUN) & (cfg_ref_sel_i ? tick_i : 1'b1);
  // A clear or a counter load both restart the prescaler phase.
  assign w_presc_clr = clr_i | cnt_wr_i;
  // clr and load take priority; an increment arriving with either is lost.
  assign w_inc_eff   = w_inc & ~clr_i & ~cnt_wr_i;
  assign w_match     = (r_cnt == cmp_i);
  assign w_all_ones  = &r_cnt;
  assign w_fire      = w_inc_eff & w_match;

  timer_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_presc (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .evt_i       (w_evt),
    .cfg_presc_i (cfg_presc_i),
    .clr_i       (w_presc_clr),
    .inc_o       (w_inc)
  );

  // Next-state decode; DONE only leaves through IDLE so a one-shot never re-arms itself.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (cfg_en_i && !clr_i) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!cfg_en_i) begin
          w_state_nxt = IDLE;
        end else if (w_fire && cfg_oneshot_i) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (!cfg_en_i || clr_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register plus registered busy flag tracking the RUN state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
    end
  end

  // Main counter: clear > load > increment; wraps to zero on match or overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
    end else if (clr_i) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
    end else if (cnt_wr_i) begin
      r_cnt <= cnt_wdata_i;
    end else if (w_inc_eff) begin
      if (w_match || w_all_ones) begin
        r_cnt <= {CNT_WIDTH{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Interrupt pulse: high for exactly the cycle after a matching increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_fire;
    end
  end

  assign cnt_o  = r_cnt;
  assign irq_o  = r_irq;
  assign busy_o = r_busy;

endmodule : timer_tick_counter
